// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan driver.
//   seg7_code_t     - 4-bit hex digit code
//   SEG_0 .. SEG_F  - active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_OFF         - all segments dark
package seg7_pkg;

  typedef logic [3:0] seg7_code_t;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex-to-7-segment transcoder.
//   code  in  4  - hex digit 0..F
//   seg_n out 7  - active-low segments {g,f,e,d,c,b,a}
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  seg7_code_t  code,
  output logic [6:0]  seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    case (code)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an N-digit common-anode
// 7-segment display with per-digit blank, blink and decimal point.
//   clk, rst            - clock, async active-high reset
//   load                - capture all *_in buses into shadow registers
//   digits_in [4N]      - digit i code in bits [4i+3:4i], digit 0 rightmost
//   blank_in/blink_in/dp_in [N] - per-digit blank, blink, decimal point
//   enable              - 0 forces outputs dark, scanning continues
//   seg_n [7], dp_n, an_n [N]   - registered active-low pin drives
//   frame_tick          - one-cycle pulse when digit 0 is driven again
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [N_DIGITS-1:0]   blink_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  enable,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_tick
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [FRM_W-1:0]    frm_cnt;
  logic                blink_ph;
  logic                wrap_q;

  seg7_code_t          digit_sh [N_DIGITS];
  logic [N_DIGITS-1:0] blank_sh;
  logic [N_DIGITS-1:0] blink_sh;
  logic [N_DIGITS-1:0] dp_sh;

  logic                slot_end;
  logic                frame_end;
  logic                dark;
  seg7_code_t          cur_code;
  logic [6:0]          cur_seg;
  logic [N_DIGITS-1:0] cur_onehot;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Scan counters. blink_ph flips on the same edge that idx returns to 0,
  // so a blinking digit can only change state at a slot boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      idx      <= '0;
      frm_cnt  <= '0;
      blink_ph <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + DIV_W'(1);
      if (slot_end)
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      if (frame_end) begin
        if (frm_cnt == FRM_LAST) begin
          frm_cnt  <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          frm_cnt <= frm_cnt + FRM_W'(1);
        end
      end
    end
  end

  // Shadow registers; reset leaves every digit blanked until the first load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++)
        digit_sh[i] <= '0;
      blank_sh <= '1;
      blink_sh <= '0;
      dp_sh    <= '0;
    end else if (load) begin
      for (int i = 0; i < N_DIGITS; i++)
        digit_sh[i] <= digits_in[4*i +: 4];
      blank_sh <= blank_in;
      blink_sh <= blink_in;
      dp_sh    <= dp_in;
    end
  end

  // Digit mux ahead of the single shared decoder.
  always_comb begin
    cur_code        = digit_sh[idx];
    cur_onehot      = '0;
    cur_onehot[idx] = 1'b1;
    dark            = !enable || blank_sh[idx] || (blink_sh[idx] && blink_ph);
  end

  seg7_hex_decode u_decode (
    .code  (cur_code),
    .seg_n (cur_seg)
  );

  // Pins lag idx by one cycle, so frame_tick is the frame wrap delayed twice:
  // once to reach idx=0 and once more to reach the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n       <= '1;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      wrap_q     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      wrap_q     <= frame_end;
      frame_tick <= wrap_q;
      if (dark) begin
        an_n  <= '1;
        seg_n <= SEG_OFF;
        dp_n  <= 1'b1;
      end else begin
        an_n  <= ~cur_onehot;
        seg_n <= cur_seg;
        dp_n  <= ~dp_sh[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver with
// N_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2. The reference model derives the
// scan position purely from the number of clock edges since reset release.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int B     = 2;
  localparam int FRAME = N * R;

  typedef struct {
    logic [3:0] code;
    logic [6:0] seg;
  } dec_vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  blink_in = '0;
  logic [3:0]  dp_in = '0;
  logic        enable = 1'b1;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (R),
    .BLINK_FRAMES (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .blink_in   (blink_in),
    .dp_in      (dp_in),
    .enable     (enable),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [15:0] m_dig;
  logic [3:0]  m_blank;
  logic [3:0]  m_blink;
  logic [3:0]  m_dp;

  dec_vec_t  dec_tbl [16];
  slot_vec_t slot_tbl [4];

  task automatic modelReset();
    m_dig   = '0;
    m_blank = '1;
    m_blink = '0;
    m_dp    = '0;
  endtask

  // Expected pins after the edge about to happen, from the edge count.
  task automatic modelExpect(output logic [3:0] e_an, output logic [6:0] e_seg,
                             output logic e_dp, output logic e_ft);
    int pos   = (cyc / R) % N;
    int frame = cyc / FRAME;
    bit ph    = ((frame / B) % 2) == 1;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (enable && !m_blank[pos] && !(m_blink[pos] && ph)) begin
      e_an[pos] = 1'b0;
      e_seg     = dec_tbl[m_dig[4*pos +: 4]].seg;
      e_dp      = ~m_dp[pos];
    end
    e_ft = (cyc > 0) && ((cyc % FRAME) == 0);
  endtask

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp, input logic e_ft);
    checks++;
    if (an_n === e_an && seg_n === e_seg && dp_n === e_dp && frame_tick === e_ft)
      passes++;
    else
      $display("[TB] FAIL %s (cyc %0d): an_n=%b seg_n=%b dp_n=%b frame_tick=%b, expected an_n=%b seg_n=%b dp_n=%b frame_tick=%b",
               name, cyc, an_n, seg_n, dp_n, frame_tick, e_an, e_seg, e_dp, e_ft);
  endtask

  // One clock: predict, let the edge happen, update model shadow, compare.
  task automatic applyStimulus(input string name);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_ft;
    @(posedge clk);
    modelExpect(e_an, e_seg, e_dp, e_ft);
    if (load) begin
      m_dig   = digits_in;
      m_blank = blank_in;
      m_blink = blink_in;
      m_dp    = dp_in;
    end
    cyc++;
    #1;
    checkOutput(name, e_an, e_seg, e_dp, e_ft);
  endtask

  task automatic waitFrameStart(input string name);
    int n = 0;
    applyStimulus(name);
    while (frame_tick !== 1'b1 && n < 2 * FRAME) begin
      applyStimulus(name);
      n++;
    end
    checkField({name, "_frame_start"}, {15'd0, frame_tick}, 16'd1);
  endtask

  task automatic loadData(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                          input logic [3:0] dp, input string name);
    digits_in = d;
    blank_in  = bl;
    blink_in  = bk;
    dp_in     = dp;
    load      = 1'b1;
    applyStimulus(name);
    load      = 1'b0;
  endtask

  initial begin
    int ft_cnt;
    int ft_first;
    int lit_cnt;
    int d1_cnt;
    int dp_cnt;
    int n;

    dec_tbl[0]  = '{4'h0, 7'b1000000};
    dec_tbl[1]  = '{4'h1, 7'b1111001};
    dec_tbl[2]  = '{4'h2, 7'b0100100};
    dec_tbl[3]  = '{4'h3, 7'b0110000};
    dec_tbl[4]  = '{4'h4, 7'b0011001};
    dec_tbl[5]  = '{4'h5, 7'b0010010};
    dec_tbl[6]  = '{4'h6, 7'b0000010};
    dec_tbl[7]  = '{4'h7, 7'b1111000};
    dec_tbl[8]  = '{4'h8, 7'b0000000};
    dec_tbl[9]  = '{4'h9, 7'b0010000};
    dec_tbl[10] = '{4'hA, 7'b0001000};
    dec_tbl[11] = '{4'hB, 7'b0000011};
    dec_tbl[12] = '{4'hC, 7'b1000110};
    dec_tbl[13] = '{4'hD, 7'b0100001};
    dec_tbl[14] = '{4'hE, 7'b0000110};
    dec_tbl[15] = '{4'hF, 7'b0001110};

    slot_tbl[0] = '{4'b1110, 7'b0010000};
    slot_tbl[1] = '{4'b1101, 7'b0001000};
    slot_tbl[2] = '{4'b1011, 7'b1000000};
    slot_tbl[3] = '{4'b0111, 7'b1000110};

    // Reset state, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    modelReset();

    // Scenario 1: no load, display stays dark, frame_tick every frame.
    ft_cnt   = 0;
    ft_first = -1;
    lit_cnt  = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus("idle");
      if (an_n !== 4'hF || seg_n !== 7'h7F) lit_cnt++;
      if (frame_tick === 1'b1) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = cyc - 1;
      end
    end
    checkField("idle_dark_cycles", 16'(lit_cnt), 16'd0);
    checkField("idle_tick_count", 16'(ft_cnt), 16'd3);
    checkField("idle_first_tick", 16'(ft_first), 16'd16);

    // Scenario 2: C0A9 scanned slot by slot.
    loadData(16'hC0A9, 4'b0000, 4'b0000, 4'b0000, "scan_load");
    waitFrameStart("scan");
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) applyStimulus("scan");
      checkField($sformatf("scan_an_%0d", j), {12'd0, an_n}, {12'd0, slot_tbl[j / R].an});
      checkField($sformatf("scan_seg_%0d", j), {9'd0, seg_n}, {9'd0, slot_tbl[j / R].seg});
    end

    // Scenario 3: every code through digit 0.
    for (int c = 0; c < 16; c++) begin
      loadData({12'h000, dec_tbl[c].code}, 4'b1110, 4'b0000, 4'b0000, "decode_load");
      n = 0;
      applyStimulus("decode_wait");
      while (an_n !== 4'b1110 && n < 2 * FRAME) begin
        applyStimulus("decode_wait");
        n++;
      end
      checkField($sformatf("decode_an_%0h", c), {12'd0, an_n}, 16'h000E);
      checkField($sformatf("decode_seg_%0h", c), {9'd0, seg_n}, {9'd0, dec_tbl[c].seg});
    end

    // Scenario 4: digit 1 blinks, digit 0 carries its decimal point.
    loadData(16'h1234, 4'b0000, 4'b0010, 4'b0001, "blink_load");
    waitFrameStart("blink");
    d1_cnt = 0;
    dp_cnt = 0;
    for (int j = 0; j < 8 * FRAME; j++) begin
      if (j > 0) applyStimulus("blink");
      if (an_n === 4'b1101) d1_cnt++;
      if (an_n === 4'b1110 && dp_n === 1'b0) dp_cnt++;
    end
    checkField("blink_digit1_lit_cycles", 16'(d1_cnt), 16'd16);
    checkField("blink_digit0_dp_cycles", 16'(dp_cnt), 16'd32);

    // Scenario 5: load on the edge where the scan moves from digit 1 to 2.
    loadData(16'h3210, 4'b0000, 4'b0000, 4'b0000, "boundary_setup");
    while ((cyc % FRAME) != 7) applyStimulus("boundary_align");
    digits_in = 16'h3E10;
    load      = 1'b1;
    applyStimulus("boundary_load");
    load      = 1'b0;
    checkField("boundary_prev_an", {12'd0, an_n}, 16'h000D);
    applyStimulus("boundary_first");
    checkField("boundary_digit2_an", {12'd0, an_n}, 16'h000B);
    checkField("boundary_digit2_seg", {9'd0, seg_n}, 16'h0006);

    // Scenario 6: asynchronous reset in the middle of digit 2's slot.
    loadData(16'h5678, 4'b0000, 4'b0000, 4'b0000, "areset_setup");
    while ((cyc % FRAME) != 10) applyStimulus("areset_align");
    checkField("areset_pre_an", {12'd0, an_n}, 16'h000B);
    #2 rst = 1'b1;
    #1;
    checkOutput("areset_immediate", 4'hF, 7'h7F, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    modelReset();
    lit_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus("areset_blank");
      if (an_n !== 4'hF) lit_cnt++;
    end
    checkField("areset_blank_cycles", 16'(lit_cnt), 16'd0);
    loadData(16'h4321, 4'b0000, 4'b0000, 4'b0000, "areset_load");
    applyStimulus("areset_restart");
    checkField("areset_restart_an", {12'd0, an_n}, 16'h000E);
    checkField("areset_restart_seg", {9'd0, seg_n}, 16'h0079);

    // Randomized traffic against the model, including loads while disabled.
    for (int i = 0; i < 400; i++) begin
      digits_in = 16'($urandom);
      blank_in  = 4'($urandom) & 4'($urandom);
      blink_in  = 4'($urandom);
      dp_in     = 4'($urandom);
      load      = ($urandom_range(0, 5) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      applyStimulus("random");
    end
    load   = 1'b0;
    enable = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display. It generalises the single-digit hex transcoder to full 0–F decode and a parametrised digit count. It adds per-digit blanking, blinking and decimal point, and latches display data through a load strobe. It sits between the parking-occupancy logic, which presents packed 4-bit digit codes, and the board's segment and anode pins.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits; must be ≥1.
- `REFRESH_DIV`, 100000: clock cycles each digit is driven per scan slot; must be ≥2.
- `BLINK_FRAMES`, 64: complete scan frames per blink half-period; must be ≥1.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: at an edge where `load`=1, all `*_in` buses are captured into shadow registers.
- `digits_in` in 4*N_DIGITS: digit i code is in bits [4i+3:4i]; digit 0 is rightmost.
- `blank_in` in N_DIGITS: 1 turns digit i fully off, including its DP.
- `blink_in` in N_DIGITS: 1 blinks digit i.
- `dp_in` in N_DIGITS: 1 lights the decimal point of digit i.
- `enable` in 1: 0 forces all outputs to the off state; counters keep running.
- `seg_n` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp_n` out 1: decimal point, active-low.
- `an_n` out N_DIGITS: digit anodes, active-low, one-hot when a digit is lit.
- `frame_tick` out 1: one-cycle pulse at the start of each scan frame.

## Operation
- Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Off pattern is 1111111.
- `div_cnt`, width $clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1 and then wraps. At the terminal count, `idx` advances. `idx` wraps from N_DIGITS-1 to 0.
- When `idx` wraps, `frm_cnt` increments. When `frm_cnt` reaches BLINK_FRAMES-1 and the frame wraps, `frm_cnt` clears and `blink_ph` toggles.
- Registered outputs for the current `idx`, taken from the shadow registers:
  - If `enable`=0 or `blank[idx]`=1 or (`blink[idx]` & `blink_ph`): `an_n` is all 1, `seg_n`=1111111, `dp_n`=1.
  - Otherwise: `an_n` has only bit `idx` at 0, `seg_n`=decode(`digit[idx]`), `dp_n`=~`dp[idx]`.
- The shadow registers hold their value until the next `load`. `load` is honoured even while `enable`=0.
- Reset, asynchronous: `div_cnt`=0, `idx`=0, `frm_cnt`=0, `blink_ph`=0, shadow digits=0, shadow blank all 1, shadow blink=0, shadow dp=0. Outputs go to `an_n` all 1, `seg_n`=1111111, `dp_n`=1, `frame_tick`=0.
- Reset asserted mid-frame aborts the scan immediately. After release, scanning restarts at digit 0 with the display blank until the first `load`.

## Timing
- `load` captured at edge k: the new data appears on the outputs from edge k+1, provided the digit is in its slot.
- Output latency is one cycle from `idx`/shadow to the pins. Each digit is lit for exactly REFRESH_DIV cycles per frame. Frame length is N_DIGITS*REFRESH_DIV cycles.
- `frame_tick` is high for exactly the first cycle in which digit 0 is driven again. It is not asserted for the first frame after reset.
- `load` coinciding with a slot boundary: the next digit is driven with the new data.
- A `blink_ph` toggle takes effect at the same edge digit 0 starts. Blink therefore never changes mid-slot.
- `enable` changes are reflected on the outputs one cycle later. The scan position is unaffected.

## Structure
- Package `seg7_pkg`:
  - constants `SEG_0`..`SEG_F` and `SEG_OFF`=7'h7F
  - a `seg7_code_t` 4-bit typedef
- Sub-module `seg7_hex_decode`: combinational, 4-bit code in, 7-bit active-low pattern out. It is instantiated once after the digit mux.
- The top level holds the counters, shadow registers, blink logic and the output registers.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
1. Reset, then no `load`:
   - `an_n`=1111 and `seg_n`=1111111 for 64 cycles.
   - `frame_tick` pulses every 16 cycles, starting at cycle 16.
2. Load `digits_in`=16'hC0A9, `blank_in`=0, `enable`=1:
   - Per frame, `an_n` cycles 1110, 1101, 1011, 0111, 4 cycles each.
   - `seg_n` is 0010000, 0001000, 1000000, 1000110 respectively.
3. Sweep all codes 0–F through digit 0 with `load` → `seg_n` matches the decode list for each code. 13–15 show d, E, F, not 0.
4. `blink_in`=0010, `dp_in`=0001:
   - Digit 1 is lit for 2 frames, then dark for 2 frames, repeating.
   - Digit 0 shows `dp_n`=0 throughout.
5. `load` asserted on the last cycle of digit 1's slot with new digit 2 data → digit 2 shows the new pattern from its first cycle.
6. `rst` pulsed mid-slot of digit 2 → outputs go to the off state in the same cycle, without waiting for a clock edge. After release, scanning restarts at digit 0 and the shadow registers are back at reset values.
